hd44780_driver: RTL and testbench



---
 rtl/hd44780_driver.sv | 185 ++++++++++++++++++
 tb/tb_hd44780_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_driver.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_driver
// Brief    : Write-only 8-bit HD44780 initialiser and fixed-message writer.
//            Optional second line enabled by defining HD44780_LINE2_EN.
// Revision : 1.0 - initial release
// ============================================================================

module hd44780_driver #(
    parameter int US_DIV = 1,
    parameter int POR_US = 15000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_clk,
    output logic [7:0] lcd_data
);

    localparam int c_por_cyc = POR_US * US_DIV;
    localparam int c_cnt_w   = (c_por_cyc >= (1 << 24)) ? $clog2(c_por_cyc + 1) : 24;

`ifdef HD44780_LINE2_EN
    localparam logic [5:0] c_last_idx = 6'd33;
`else
    localparam logic [5:0] c_last_idx = 6'd20;
`endif

    // POR spans the reset interval plus POR_US*US_DIV edges, so the first
    // SETUP lands on cycle POR_US*US_DIV counted from the first edge.
    localparam logic [c_cnt_w-1:0] c_por_last = c_cnt_w'(c_por_cyc);
    localparam logic [c_cnt_w-1:0] c_us_last  = c_cnt_w'(US_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_us_div   = c_cnt_w'(US_DIV);
    localparam logic [12:0]        c_d40      = 13'd40;

    typedef enum logic [2:0] {
        S_POR   = 3'd0,
        S_SETUP = 3'd1,
        S_EHIGH = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ROM entry layout: {rs, data[7:0], post-delay_us[12:0]}
    function automatic logic [21:0] ins(input logic [7:0] b, input logic [12:0] d);
        return {1'b0, b, d};
    endfunction

    function automatic logic [21:0] chr(input logic [7:0] c);
        return {1'b1, c, c_d40};
    endfunction

    function automatic logic [21:0] rom_entry(input logic [5:0] idx);
        logic [21:0] e;
        e = '0;
        case (idx)
            6'd0:  e = ins(8'h30, 13'd4100);
            6'd1:  e = ins(8'h30, 13'd100);
            6'd2:  e = ins(8'h30, c_d40);
            6'd3:  e = ins(8'h38, c_d40);
            6'd4:  e = ins(8'h08, c_d40);
            6'd5:  e = ins(8'h01, 13'd1640);
            6'd6:  e = ins(8'h06, c_d40);
            6'd7:  e = ins(8'h0C, c_d40);
            6'd8:  e = chr("H");
            6'd9:  e = chr("e");
            6'd10: e = chr("l");
            6'd11: e = chr("l");
            6'd12: e = chr("o");
            6'd13: e = chr(",");
            6'd14: e = chr(" ");
            6'd15: e = chr("i");
            6'd16: e = chr("C");
            6'd17: e = chr("E");
            6'd18: e = chr("4");
            6'd19: e = chr("0");
            6'd20: e = chr("!");
`ifdef HD44780_LINE2_EN
            6'd21: e = ins(8'hC0, c_d40);
            6'd22: e = chr("H");
            6'd23: e = chr("D");
            6'd24: e = chr("4");
            6'd25: e = chr("4");
            6'd26: e = chr("7");
            6'd27: e = chr("8");
            6'd28: e = chr("0");
            6'd29: e = chr(" ");
            6'd30: e = chr("d");
            6'd31: e = chr("e");
            6'd32: e = chr("m");
            6'd33: e = chr("o");
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [5:0]          r_idx;
    logic [12:0]         r_dly;

    logic [5:0]          w_sel_idx;
    logic [21:0]         w_ent;
    logic [c_cnt_w-1:0]  w_wait_last;

    // POR fetches entry 0; WAIT prefetches the entry that the next SETUP drives.
    assign w_sel_idx   = (r_state == S_POR) ? r_idx : (r_idx + 6'd1);
    assign w_ent       = rom_entry(w_sel_idx);
    assign w_wait_last = (c_cnt_w'(r_dly) * c_us_div) - c_cnt_w'(1);

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_POR;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_dly    <= '0;
            lcd_rs   <= 1'b0;
            lcd_clk  <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (r_state)
                S_POR: begin
                    if (r_cnt == c_por_last) begin
                        r_cnt    <= '0;
                        r_state  <= S_SETUP;
                        lcd_rs   <= w_ent[21];
                        lcd_data <= w_ent[20:13];
                        r_dly    <= w_ent[12:0];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_us_last) begin
                        r_cnt   <= '0;
                        r_state <= S_EHIGH;
                        lcd_clk <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_EHIGH: begin
                    if (r_cnt == c_us_last) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                        lcd_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        r_cnt <= '0;
                        if (r_idx == c_last_idx) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx    <= r_idx + 6'd1;
                            r_state  <= S_SETUP;
                            lcd_rs   <= w_ent[21];
                            lcd_data <= w_ent[20:13];
                            r_dly    <= w_ent[12:0];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_DONE: begin
                    lcd_clk <= 1'b0;
                end
                default: begin
                    r_state <= S_POR;
                    r_cnt   <= '0;
                    lcd_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hd44780_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hd44780_driver
// Brief    : Self-checking bench for hd44780_driver (1 MHz clk, US_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================

module tb_hd44780_driver;

    localparam int US_DIV = 1;
    localparam int POR_US = 15000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_clk;
    logic [7:0] lcd_data;

    hd44780_driver #(.US_DIV(US_DIV), .POR_US(POR_US)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_clk  (lcd_clk),
        .lcd_data (lcd_data)
    );

    always #500 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Cycle index: 0 on the first rising edge after rst_n deasserts.
    int cyc = -1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         rise;
        int         width;
        logic       rs;
        logic [7:0] data;
    } strobe_t;

    strobe_t    sq[$];
    int         hold_bad = 0;
    int         rw_bad   = 0;
    logic       mon_clk  = 1'b0;
    logic       mon_rs   = 1'b0;
    logic [7:0] mon_data = 8'h00;
    int         mon_rise = 0;

    // Strobe recorder, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_clk  = 1'b0;
            mon_rs   = lcd_rs;
            mon_data = lcd_data;
        end else begin
            if (lcd_rw !== 1'b0) rw_bad++;
            if (((lcd_rs !== mon_rs) || (lcd_data !== mon_data)) && (lcd_clk || mon_clk))
                hold_bad++;
            if (lcd_clk === 1'b1 && !mon_clk) mon_rise = cyc;
            if (lcd_clk === 1'b0 && mon_clk)
                sq.push_back('{rise: mon_rise, width: cyc - mon_rise, rs: lcd_rs, data: lcd_data});
            mon_clk  = (lcd_clk === 1'b1);
            mon_rs   = lcd_rs;
            mon_data = lcd_data;
        end
    end

    // Reference model: transfer list and strobe times derived from the timing rules.
    int    m_rs[$];
    int    m_data[$];
    int    m_dly[$];
    int    m_rise[$];
    int    m_total;
    string m_msg;

    task automatic push_entry(input int rs, input int data, input int dly);
        m_rs.push_back(rs);
        m_data.push_back(data);
        m_dly.push_back(dly);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_bound", 32'(cyc >= target), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rs"},   32'(lcd_rs),   32'd0);
        chk({tag, "_rw"},   32'(lcd_rw),   32'd0);
        chk({tag, "_clk"},  32'(lcd_clk),  32'd0);
        chk({tag, "_data"}, 32'(lcd_data), 32'd0);
    endtask

    initial begin
        string s;
        string got;
        int    t;
        int    late;
        int    target;

        push_entry(0, 'h30, 4100);
        push_entry(0, 'h30, 100);
        push_entry(0, 'h30, 40);
        push_entry(0, 'h38, 40);
        push_entry(0, 'h08, 40);
        push_entry(0, 'h01, 1640);
        push_entry(0, 'h06, 40);
        push_entry(0, 'h0C, 40);
        s = "Hello, iCE40!";
        for (int i = 0; i < s.len(); i++) push_entry(1, int'(s[i]), 40);
        m_msg = s;
`ifdef HD44780_LINE2_EN
        push_entry(0, 'hC0, 40);
        s = "HD44780 demo";
        for (int i = 0; i < s.len(); i++) push_entry(1, int'(s[i]), 40);
        m_msg = {m_msg, s};
`endif
        t = POR_US * US_DIV;
        for (int k = 0; k < m_dly.size(); k++) begin
            m_rise.push_back(t + US_DIV);
            t += (2 + m_dly[k]) * US_DIV;
        end
        m_total = t;

        // Reset held with clk running
        repeat ($urandom_range(5, 20)) begin
            @(negedge clk);
            chk_reset_vals("hold_rst");
        end

        // Full sequence from a clean release
        @(posedge clk);
        #($urandom_range(100, 400));
        sq.delete();
        hold_bad = 0;
        rw_bad   = 0;
        rst_n    = 1'b1;
        wait_cyc(m_total + 10000);

        chk("strobe_count", sq.size(), m_rise.size());
        for (int k = 0; k < m_rise.size() && k < sq.size(); k++) begin
            chk($sformatf("rise[%0d]", k),  sq[k].rise,      m_rise[k]);
            chk($sformatf("width[%0d]", k), sq[k].width,     US_DIV);
            chk($sformatf("rs[%0d]", k),    32'(sq[k].rs),   m_rs[k]);
            chk($sformatf("data[%0d]", k),  32'(sq[k].data), m_data[k]);
        end
        got  = "";
        late = 0;
        foreach (sq[k]) begin
            if (sq[k].rs) got = $sformatf("%s%c", got, sq[k].data);
            if (sq[k].rise >= m_total) late++;
        end
        checks++;
        assert (got == m_msg) else begin
            errors++;
            $error("FAIL message: observed=\"%s\" expected=\"%s\"", got, m_msg);
        end
        chk("strobes_after_done", late, 0);
        chk("rw_low", rw_bad, 0);
        chk("hold_stable", hold_bad, 0);

        // Async reset from DONE, no clk edge inside the pulse
        @(posedge clk);
        #($urandom_range(100, 400));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_done");
        #499;
        sq.delete();
        hold_bad = 0;
        rst_n    = 1'b1;

        // Reset pulse inside the clear wait
        target = m_rise[5] + $urandom_range(2, m_dly[5] * US_DIV - 1);
        wait_cyc(target);
        chk("clear_wait_data", 32'(lcd_data), m_data[5]);
        chk("clear_wait_clk",  32'(lcd_clk),  32'd0);
        @(posedge clk);
        #($urandom_range(100, 400));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_clear");
        #499;
        sq.delete();
        hold_bad = 0;
        rst_n    = 1'b1;

        wait_cyc(m_rise[1] + 2);
        chk("restart_count", sq.size(), 2);
        for (int k = 0; k < 2 && k < sq.size(); k++) begin
            chk($sformatf("restart_rise[%0d]", k), sq[k].rise,      m_rise[k]);
            chk($sformatf("restart_rs[%0d]", k),   32'(sq[k].rs),   m_rs[k]);
            chk($sformatf("restart_data[%0d]", k), 32'(sq[k].data), m_data[k]);
        end

        // Async reset while E is high
        wait_cyc(m_rise[2]);
        chk("strobe_high", 32'(lcd_clk), 32'd1);
        chk("restart_hold_stable", hold_bad, 0);
        #100;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_mid_strobe");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
